// File: rtl/credential_entry.sv
// credential_entry: keypad-side credential producer for AccessControl.
// Collects NUM_DIGITS hex digits, presents the assembled credential with a
// load strobe, waits for the grant response and tracks the granted session.
// Optional retry lockout is compiled in when RETRY_LOCKOUT_EN is defined.
module credential_entry #(
   parameter int NUM_DIGITS     = 4,
   parameter int LOAD_CYCLES    = 2,
   parameter int GRANT_TIMEOUT  = 8,
   parameter int MAX_FAILS      = 3,
   parameter int LOCKOUT_CYCLES = 1000
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [3:0]              _Digit_In,
   input  logic                    _Digit_Valid,
   input  logic                    _Enter,
   input  logic                    _Clear,
   input  logic                    _Logout,
   input  logic                    _Access_grant,
   output logic [4*NUM_DIGITS-1:0] _Data_Out,
   output logic                    _Data_Out_Load,
   output logic [2:0]              _Digit_Count,
   output logic                    _Session_Active,
   output logic                    _Denied,
   output logic                    _Locked
);

   localparam int W    = 4 * NUM_DIGITS;
   localparam int T_LW = (LOAD_CYCLES > GRANT_TIMEOUT) ? LOAD_CYCLES : GRANT_TIMEOUT;
`ifdef RETRY_LOCKOUT_EN
   localparam int T_MAX = (LOCKOUT_CYCLES > T_LW) ? LOCKOUT_CYCLES : T_LW;
`else
   localparam int T_MAX = T_LW;
`endif
   localparam int            TW       = $clog2(T_MAX + 1);
   localparam logic [TW-1:0] LOAD_END = TW'(LOAD_CYCLES - 1);
   localparam logic [TW-1:0] WAIT_END = TW'(GRANT_TIMEOUT - 1);
   localparam logic [2:0]    FULL     = 3'(NUM_DIGITS);

   // The digit counter is 3 bits wide and every timed phase needs at least one cycle
   if (NUM_DIGITS < 2 || NUM_DIGITS > 7 || LOAD_CYCLES < 1 || GRANT_TIMEOUT < 1 ||
       MAX_FAILS < 1 || LOCKOUT_CYCLES < 1) begin : g_param_check
      $error("credential_entry: parameter out of range");
   end

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      COLLECT = 3'd1,
      LOAD    = 3'd2,
      WAIT    = 3'd3,
      GRANTED = 3'd4,
      DENIED  = 3'd5,
      LOCKED  = 3'd6
   } state_t;

   state_t        state_reg, state_next;
   logic [W-1:0]  sr_reg, sr_next;
   logic [2:0]    count_reg, count_next;
   logic [TW-1:0] timer_reg, timer_next;
   logic          load_reg, load_next;
   logic          session_reg, session_next;
   logic          denied_reg, denied_next;

`ifdef RETRY_LOCKOUT_EN
   localparam int            FW       = $clog2(MAX_FAILS + 1);
   localparam logic [FW-1:0] FAIL_MAX = FW'(MAX_FAILS);
   logic [FW-1:0] fail_reg, fail_next;
   logic          locked_reg, locked_next;

   // Consecutive-denial counter and lockout flag; reset cancels any lockout
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fail_reg   <= '0;
         locked_reg <= 1'b0;
      end else begin
         fail_reg   <= fail_next;
         locked_reg <= locked_next;
      end
   end

   assign _Locked = locked_reg;
`else
   assign _Locked = 1'b0;
`endif

   // State, credential shift register, counters and registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg   <= IDLE;
         sr_reg      <= '0;
         count_reg   <= '0;
         timer_reg   <= '0;
         load_reg    <= 1'b0;
         session_reg <= 1'b0;
         denied_reg  <= 1'b0;
      end else begin
         state_reg   <= state_next;
         sr_reg      <= sr_next;
         count_reg   <= count_next;
         timer_reg   <= timer_next;
         load_reg    <= load_next;
         session_reg <= session_next;
         denied_reg  <= denied_next;
      end
   end

   // Next-state and next-output decode; strobe priority is Clear > Enter > Digit
   always_comb begin
      state_next   = state_reg;
      sr_next      = sr_reg;
      count_next   = count_reg;
      timer_next   = timer_reg;
      load_next    = 1'b0;
      session_next = session_reg;
      denied_next  = 1'b0;
`ifdef RETRY_LOCKOUT_EN
      fail_next    = fail_reg;
      locked_next  = locked_reg;
`endif
      case (state_reg)
         IDLE: begin
            if (_Clear) begin
               sr_next    = '0;
               count_next = '0;
            end else if (!_Enter && _Digit_Valid) begin
               sr_next    = {sr_reg[W-5:0], _Digit_In};
               count_next = 3'd1;
               state_next = COLLECT;
            end
         end
         COLLECT: begin
            if (_Clear) begin
               sr_next    = '0;
               count_next = '0;
               state_next = IDLE;
            end else if (_Enter) begin
               // A short entry is simply ignored; the partial digits stay put
               if (count_reg == FULL) begin
                  state_next = LOAD;
                  load_next  = 1'b1;
                  timer_next = '0;
               end
            end else if (_Digit_Valid && count_reg != FULL) begin
               sr_next    = {sr_reg[W-5:0], _Digit_In};
               count_next = count_reg + 3'd1;
            end
         end
         LOAD: begin
            if (timer_reg == LOAD_END) begin
               state_next = WAIT;
               timer_next = '0;
            end else begin
               load_next  = 1'b1;
               timer_next = timer_reg + 1'b1;
            end
         end
         WAIT: begin
            // Grant is checked before the timeout so a last-cycle grant still wins
            if (_Access_grant) begin
               state_next   = GRANTED;
               session_next = 1'b1;
`ifdef RETRY_LOCKOUT_EN
               fail_next    = '0;
`endif
            end else if (timer_reg == WAIT_END) begin
               state_next  = DENIED;
               denied_next = 1'b1;
               sr_next     = '0;
               count_next  = '0;
`ifdef RETRY_LOCKOUT_EN
               fail_next   = (fail_reg == FAIL_MAX) ? fail_reg : fail_reg + 1'b1;
`endif
            end else begin
               timer_next = timer_reg + 1'b1;
            end
         end
         GRANTED: begin
            if (_Logout) begin
               state_next   = IDLE;
               session_next = 1'b0;
               sr_next      = '0;
               count_next   = '0;
            end
         end
         DENIED: begin
            state_next = IDLE;
`ifdef RETRY_LOCKOUT_EN
            if (fail_reg == FAIL_MAX) begin
               state_next  = LOCKED;
               locked_next = 1'b1;
               timer_next  = '0;
            end
`endif
         end
`ifdef RETRY_LOCKOUT_EN
         LOCKED: begin
            if (timer_reg == TW'(LOCKOUT_CYCLES - 1)) begin
               state_next  = IDLE;
               locked_next = 1'b0;
               fail_next   = '0;
            end else begin
               timer_next = timer_reg + 1'b1;
            end
         end
`endif
         default: state_next = IDLE;
      endcase
   end

   assign _Data_Out       = sr_reg;
   assign _Digit_Count    = count_reg;
   assign _Data_Out_Load  = load_reg;
   assign _Session_Active = session_reg;
   assign _Denied         = denied_reg;

endmodule

// File: tb/tb_credential_entry.sv
// tb_credential_entry: self-checking bench for credential_entry.
// Directed vector table, multi-cycle corner sequences and randomized
// credential attempts checked against an attempt-level expectation model.
module tb_credential_entry;

   localparam int LOAD_CYCLES    = 2;
   localparam int GRANT_TIMEOUT  = 8;
   localparam int MAX_FAILS      = 3;
   localparam int LOCKOUT_CYCLES = 20;
`ifdef RETRY_LOCKOUT_EN
   localparam bit LOCK_EN = 1'b1;
`else
   localparam bit LOCK_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  _Digit_In;
   logic        _Digit_Valid, _Enter, _Clear, _Logout, _Access_grant;
   logic [15:0] _Data_Out;
   logic        _Data_Out_Load;
   logic [2:0]  _Digit_Count;
   logic        _Session_Active, _Denied, _Locked;

   int total = 0;
   int bad   = 0;
   int fails = 0;   // model: consecutive denials since last grant/lockout/reset

   always #5 clk = ~clk;

   credential_entry #(.LOCKOUT_CYCLES(LOCKOUT_CYCLES)) dut (
      .clk            (clk),
      .rst            (rst),
      ._Digit_In      (_Digit_In),
      ._Digit_Valid   (_Digit_Valid),
      ._Enter         (_Enter),
      ._Clear         (_Clear),
      ._Logout        (_Logout),
      ._Access_grant  (_Access_grant),
      ._Data_Out      (_Data_Out),
      ._Data_Out_Load (_Data_Out_Load),
      ._Digit_Count   (_Digit_Count),
      ._Session_Active(_Session_Active),
      ._Denied        (_Denied),
      ._Locked        (_Locked)
   );

   typedef struct {
      logic        dv;
      logic [3:0]  d;
      logic        en, cl, lo, gr;
      logic [2:0]  cnt;
      logic [15:0] data;
      logic        ld, ss;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic dv, input logic [3:0] d, input logic en,
                               input logic cl, input logic lo, input logic gr,
                               input logic [2:0] cnt, input logic [15:0] data,
                               input logic ld, input logic ss);
      vec_t v;
      v.dv = dv; v.d = d; v.en = en; v.cl = cl; v.lo = lo; v.gr = gr;
      v.cnt = cnt; v.data = data; v.ld = ld; v.ss = ss;
      return v;
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      _Digit_Valid = 1'b0; _Digit_In = 4'h0; _Enter = 1'b0;
      _Clear = 1'b0; _Logout = 1'b0; _Access_grant = 1'b0;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic key(input logic [3:0] d);
      _Digit_In = d; _Digit_Valid = 1'b1;
      cyc();
      _Digit_Valid = 1'b0;
   endtask

   // One credential submission from IDLE, checked against the expected outcome
   task automatic attempt(input logic [15:0] cred, input int grant_at, input bit noise,
                          input bit rst_in_lock);
      int    load_len, k, outcome, lock_len;
      bit    stable, exp_grant, exp_lock, did_rst;
      int    exp_k;
      string res;
      exp_grant = (grant_at >= 1 && grant_at <= GRANT_TIMEOUT);
      exp_k     = exp_grant ? grant_at : GRANT_TIMEOUT;
      if (noise) begin
         key(4'($urandom_range(0, 15)));
         key(4'($urandom_range(0, 15)));
         _Clear = 1'b1; cyc(); _Clear = 1'b0;
      end
      for (int i = 3; i >= 0; i--) key(cred[i*4 +: 4]);
      if (noise) key(4'($urandom_range(0, 15)));
      chk("entry_data", 32'(_Data_Out), 32'(cred));
      chk("entry_count", 32'(_Digit_Count), 4);
      _Enter = 1'b1; cyc(); _Enter = 1'b0;
      chk("load_first", 32'(_Data_Out_Load), 1);
      load_len = 0; stable = 1'b1;
      while (_Data_Out_Load && load_len < 20) begin
         load_len++;
         if (_Data_Out !== cred) stable = 1'b0;
         cyc();
      end
      chk("load_len", load_len, LOAD_CYCLES);
      chk("load_stable", 32'(stable), 1);
      outcome = 0; k = 0;
      while (outcome == 0 && k < GRANT_TIMEOUT + 4) begin
         k++;
         _Access_grant = (k == grant_at);
         cyc();
         _Access_grant = 1'b0;
         if (_Session_Active) outcome = 1;
         else if (_Denied) outcome = 2;
      end
      chk("outcome", outcome, exp_grant ? 1 : 2);
      chk("wait_cycles", k, exp_k);
      res = (outcome == 1) ? "granted" : (outcome == 2) ? "denied" : "no response";
      $display("attempt cred=%h grant_at=%0d noise=%0d: %s after %0d wait cycles",
               cred, grant_at, noise, res, k);
      if (exp_grant) begin
         fails = 0;
         repeat ($urandom_range(0, 3)) key(4'($urandom_range(0, 15)));
         chk("session_hold", 32'(_Session_Active), 1);
         chk("session_count", 32'(_Digit_Count), 4);
         chk("session_data", 32'(_Data_Out), 32'(cred));
         _Logout = 1'b1; cyc(); _Logout = 1'b0;
         chk("logout_session", 32'(_Session_Active), 0);
         chk("logout_data", 32'(_Data_Out), 0);
         chk("logout_count", 32'(_Digit_Count), 0);
      end else begin
         fails++;
         exp_lock = LOCK_EN && (fails == MAX_FAILS);
         cyc();
         chk("denied_width", 32'(_Denied), 0);
         chk("deny_count", 32'(_Digit_Count), 0);
         chk("deny_data", 32'(_Data_Out), 0);
         chk("lock_entry", 32'(_Locked), 32'(exp_lock));
         if (exp_lock) fails = 0;
         lock_len = 0; did_rst = 1'b0;
         while (_Locked && lock_len < 200) begin
            if (rst_in_lock && lock_len == 5) begin
               #3 rst = 1'b0;
               #1 chk("reset_unlock", 32'(_Locked), 0);
               #2 rst = 1'b1;
               did_rst = 1'b1;
               cyc();
               break;
            end
            lock_len++;
            _Digit_In = 4'($urandom_range(0, 15)); _Digit_Valid = 1'b1;
            cyc();
            _Digit_Valid = 1'b0;
         end
         if (!did_rst) chk("lock_len", lock_len, exp_lock ? LOCKOUT_CYCLES : 0);
         $display("post-denial: locked for %0d cycles, reset_in_lock=%0d", lock_len, did_rst);
         chk("lock_count", 32'(_Digit_Count), 0);
         chk("locked_after", 32'(_Locked), 0);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] cred;
      int          g;
      rst = 1'b0;
      idle_inputs();
      repeat (2) @(posedge clk);
      #1;
      chk("reset_data", 32'(_Data_Out), 0);
      chk("reset_load", 32'(_Data_Out_Load), 0);
      chk("reset_count", 32'(_Digit_Count), 0);
      chk("reset_session", 32'(_Session_Active), 0);
      chk("reset_denied", 32'(_Denied), 0);
      chk("reset_locked", 32'(_Locked), 0);
      rst = 1'b1;
      cyc();

      //          dv d    en cl lo gr  cnt data      ld ss
      tbl.push_back(mk(1, 4'h1, 0, 0, 0, 0, 3'd1, 16'h0001, 0, 0));
      tbl.push_back(mk(1, 4'h4, 0, 0, 0, 0, 3'd2, 16'h0014, 0, 0));
      tbl.push_back(mk(1, 4'h7, 0, 0, 0, 0, 3'd3, 16'h0147, 0, 0));
      tbl.push_back(mk(1, 4'h5, 1, 0, 0, 0, 3'd3, 16'h0147, 0, 0));  // Enter beats digit
      tbl.push_back(mk(1, 4'h6, 0, 0, 0, 0, 3'd4, 16'h1476, 0, 0));
      tbl.push_back(mk(1, 4'h9, 0, 0, 0, 0, 3'd4, 16'h1476, 0, 0));  // fifth digit dropped
      tbl.push_back(mk(0, 4'h0, 1, 0, 0, 0, 3'd4, 16'h1476, 1, 0));
      tbl.push_back(mk(0, 4'h0, 0, 0, 0, 0, 3'd4, 16'h1476, 1, 0));
      tbl.push_back(mk(0, 4'h0, 0, 0, 0, 0, 3'd4, 16'h1476, 0, 0));  // WAIT cycle 1 next
      tbl.push_back(mk(0, 4'h0, 0, 0, 0, 0, 3'd4, 16'h1476, 0, 0));
      tbl.push_back(mk(0, 4'h0, 0, 0, 0, 0, 3'd4, 16'h1476, 0, 0));
      tbl.push_back(mk(0, 4'h0, 0, 0, 0, 1, 3'd4, 16'h1476, 0, 1));  // grant on WAIT cycle 3
      tbl.push_back(mk(1, 4'h3, 0, 0, 0, 0, 3'd4, 16'h1476, 0, 1));
      tbl.push_back(mk(0, 4'h0, 1, 0, 0, 0, 3'd4, 16'h1476, 0, 1));
      tbl.push_back(mk(0, 4'h0, 0, 0, 1, 0, 3'd0, 16'h0000, 0, 0));  // logout
      tbl.push_back(mk(0, 4'h0, 0, 0, 1, 0, 3'd0, 16'h0000, 0, 0));
      tbl.push_back(mk(1, 4'h7, 0, 1, 0, 0, 3'd0, 16'h0000, 0, 0));  // Clear beats digit
      tbl.push_back(mk(1, 4'h1, 0, 0, 0, 0, 3'd1, 16'h0001, 0, 0));
      tbl.push_back(mk(1, 4'h4, 0, 0, 0, 0, 3'd2, 16'h0014, 0, 0));
      tbl.push_back(mk(0, 4'h0, 1, 0, 0, 0, 3'd2, 16'h0014, 0, 0));  // short Enter ignored
      tbl.push_back(mk(0, 4'h0, 0, 0, 0, 0, 3'd2, 16'h0014, 0, 0));
      tbl.push_back(mk(0, 4'h0, 0, 1, 0, 0, 3'd0, 16'h0000, 0, 0));
      tbl.push_back(mk(1, 4'h1, 0, 0, 0, 0, 3'd1, 16'h0001, 0, 0));
      tbl.push_back(mk(1, 4'h4, 0, 0, 0, 0, 3'd2, 16'h0014, 0, 0));
      tbl.push_back(mk(1, 4'h7, 0, 0, 0, 0, 3'd3, 16'h0147, 0, 0));
      tbl.push_back(mk(1, 4'h6, 0, 0, 0, 0, 3'd4, 16'h1476, 0, 0));
      tbl.push_back(mk(1, 4'h9, 0, 0, 0, 0, 3'd4, 16'h1476, 0, 0));
      tbl.push_back(mk(0, 4'h0, 1, 1, 0, 0, 3'd0, 16'h0000, 0, 0));  // Clear beats Enter
      tbl.push_back(mk(0, 4'h0, 0, 0, 0, 0, 3'd0, 16'h0000, 0, 0));

      foreach (tbl[i]) begin
         _Digit_Valid = tbl[i].dv; _Digit_In = tbl[i].d; _Enter = tbl[i].en;
         _Clear = tbl[i].cl; _Logout = tbl[i].lo; _Access_grant = tbl[i].gr;
         cyc();
         idle_inputs();
         chk($sformatf("vec%0d_count", i), 32'(_Digit_Count), 32'(tbl[i].cnt));
         chk($sformatf("vec%0d_data", i), 32'(_Data_Out), 32'(tbl[i].data));
         chk($sformatf("vec%0d_load", i), 32'(_Data_Out_Load), 32'(tbl[i].ld));
         chk($sformatf("vec%0d_session", i), 32'(_Session_Active), 32'(tbl[i].ss));
         $display("vec %0d: count=%0d data=%h load=%b session=%b",
                  i, _Digit_Count, _Data_Out, _Data_Out_Load, _Session_Active);
      end

      // Three consecutive denials, lockout, then a granted fourth try
      attempt(16'h2456, 0, 1'b0, 1'b0);
      attempt(16'h2456, 0, 1'b0, 1'b0);
      attempt(16'h2456, 0, 1'b0, 1'b0);
      attempt(16'h1476, 3, 1'b0, 1'b0);
      // Grant on the final timeout cycle still counts
      attempt(16'hbeef, GRANT_TIMEOUT, 1'b0, 1'b0);

      // Asynchronous reset while the load strobe is high
      for (int i = 3; i >= 0; i--) key(4'(16'h1476 >> (i * 4)));
      _Enter = 1'b1; cyc(); _Enter = 1'b0;
      chk("rstload_pre", 32'(_Data_Out_Load), 1);
      #3 rst = 1'b0;
      #1;
      chk("rstload_load", 32'(_Data_Out_Load), 0);
      chk("rstload_data", 32'(_Data_Out), 0);
      chk("rstload_count", 32'(_Digit_Count), 0);
      chk("rstload_session", 32'(_Session_Active), 0);
      #2 rst = 1'b1;
      fails = 0;
      cyc();
      chk("rstload_after", 32'(_Data_Out_Load), 0);
      key(4'h5);
      chk("rstload_idle_count", 32'(_Digit_Count), 1);
      chk("rstload_idle_data", 32'(_Data_Out), 32'h5);
      $display("reset during load: load=%b count=%0d", _Data_Out_Load, _Digit_Count);
      _Clear = 1'b1; cyc(); _Clear = 1'b0;

      // Reset during lockout, then one denial must not re-lock
      attempt(16'h0bad, 0, 1'b0, 1'b0);
      attempt(16'h0bad, 0, 1'b0, 1'b0);
      attempt(16'h0bad, 0, 1'b0, 1'b1);
      fails = 0;
      attempt(16'h0bad, 0, 1'b0, 1'b0);
      attempt(16'h1234, 1, 1'b1, 1'b0);

      // Randomized attempts
      for (int n = 0; n < 40; n++) begin
         cred = 16'($urandom);
         if ($urandom_range(0, 1) == 1) g = int'($urandom_range(1, GRANT_TIMEOUT));
         else if ($urandom_range(0, 1) == 1) g = 0;
         else g = int'($urandom_range(GRANT_TIMEOUT + 1, GRANT_TIMEOUT + 3));
         attempt(cred, g, 1'($urandom_range(0, 1)), 1'b0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
